fifo_rd_stream: RTL and testbench

Read-side consumer of the MAC async FIFO, running in the FIFO read-clock domain. It pops fixed-length bursts from the FIFO and presents them as a valid/ready stream with start-of-burst and end-of-burst markers. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency and downstream backpressure with no bubbles and no data loss.

---
 rtl/fifo_rd_stream.sv | 168 ++++++++++++++++
 tb/tb_fifo_rd_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain burst consumer: pops BURST_LEN-word bursts from the async FIFO and streams them out with sop/eop.
// A 2-entry output buffer plus a single in-flight slot hides the FIFO read latency without bubbles.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int PTR       = 4,
  parameter int BURST_LEN = 4,
  parameter int GAP       = 2
) (
  input  logic             rdclk,
  input  logic             reset,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_dataout,
  input  logic             fifo_rdempty,
  input  logic [PTR:0]     fifo_rdusedw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             underrun,
  output logic [15:0]      word_cnt
);

  localparam int CW = PTR + 1;
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             sop;
    logic             eop;
  } ent_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            underrun_q, underrun_d;
  logic            infl_q, infl_d;
  logic            infl_sop_q, infl_sop_d;
  logic            infl_eop_q, infl_eop_d;
  logic [1:0]      occ_q, occ_d;
  ent_t            ent0_q, ent0_d;
  ent_t            ent1_q, ent1_d;
  logic [15:0]     word_cnt_q, word_cnt_d;

  logic            pop;
  logic [2:0]      committed;
  logic            credit_ok;
  logic            last_issue;
  ent_t            new_ent;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_q.dat;
  assign out_sop   = ent0_q.sop;
  assign out_eop   = ent0_q.eop;
  assign underrun  = underrun_q;
  assign word_cnt  = word_cnt_q;

  assign pop        = out_valid & out_ready;
  // Words already owed to the buffer after this cycle's pop; a new read must still fit.
  assign committed  = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign credit_ok  = (committed < 3'd2);
  assign last_issue = (issued_q == CW'(BURST_LEN - 1));
  assign new_ent    = '{dat: fifo_dataout, sop: infl_sop_q, eop: infl_eop_q};

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    gap_d      = gap_q;
    underrun_d = underrun_q;
    infl_d     = 1'b0;
    infl_sop_d = infl_sop_q;
    infl_eop_d = infl_eop_q;
    fifo_rden  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_rdusedw >= CW'(BURST_LEN)) begin
          state_d  = S_READ;
          issued_d = '0;
        end
      end
      S_READ: begin
        if (credit_ok) begin
          if (fifo_rdempty) begin
            underrun_d = 1'b1;
          end else begin
            fifo_rden  = 1'b1;
            infl_d     = 1'b1;
            infl_sop_d = (issued_q == '0);
            infl_eop_d = last_issue;
            issued_d   = issued_q + 1'b1;
            if (last_issue) begin
              state_d = S_GAP;
              gap_d   = GW'(GAP);
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head entry always lives in ent0 so the outputs come straight from a register.
  always_comb begin
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    occ_d      = occ_q;
    word_cnt_d = word_cnt_q + 16'(pop);
    case ({infl_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      gap_q      <= '0;
      underrun_q <= 1'b0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      occ_q      <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      gap_q      <= gap_d;
      underrun_q <= underrun_d;
      infl_q     <= infl_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      occ_q      <= occ_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO model, negedge output monitor, hand-computed expectations.
module tb_fifo_rd_stream;

  logic        rdclk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_rden;
  logic [7:0]  fifo_dataout;
  logic        fifo_rdempty;
  logic [4:0]  fifo_rdusedw;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        underrun;
  logic [15:0] word_cnt;

  logic        force_empty = 1'b0;
  logic [7:0]  mem [64];
  int          wr_ptr = 0;
  int          rd_ptr;

  int          n_cmp = 0;
  int          n_err = 0;

  int          cyc = 0;
  int          rd_cnt = 0;
  int          zero_run = 1000;
  int          outst = 0;
  int          max_outst = 0;
  int          stab_err = 0;
  int          empty_rd = 0;
  logic        stall_prev = 1'b0;
  logic [9:0]  held = '0;
  logic [7:0]  rx_dat [$];
  logic        rx_sop [$];
  logic        rx_eop [$];
  int          rx_cyc [$];
  int          rd_gap [$];

  fifo_rd_stream #(.WIDTH(8), .PTR(4), .BURST_LEN(4), .GAP(2)) dut (
    .rdclk        (rdclk),
    .reset        (reset),
    .fifo_rden    (fifo_rden),
    .fifo_dataout (fifo_dataout),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdusedw (fifo_rdusedw),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .underrun     (underrun),
    .word_cnt     (word_cnt)
  );

  always #5 rdclk = ~rdclk;

  assign fifo_rdempty = (wr_ptr == rd_ptr) || force_empty;
  assign fifo_rdusedw = 5'(wr_ptr - rd_ptr);

  // FIFO model: data appears one cycle after an accepted read.
  always @(posedge rdclk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= 0;
      fifo_dataout <= 8'h00;
    end else if (fifo_rden && !fifo_rdempty) begin
      fifo_dataout <= mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(negedge rdclk) begin
    if (reset) begin
      outst      = 0;
      stall_prev = 1'b0;
    end else begin
      if (fifo_rden && fifo_rdempty) empty_rd++;
      if (fifo_rden && !fifo_rdempty) begin
        rd_cnt++;
        rd_gap.push_back(zero_run);
        zero_run = 0;
      end else begin
        zero_run++;
      end
      if (out_valid && out_ready) begin
        rx_dat.push_back(out_data);
        rx_sop.push_back(out_sop);
        rx_eop.push_back(out_eop);
        rx_cyc.push_back(cyc);
      end
      outst = outst + int'(fifo_rden && !fifo_rdempty) - int'(out_valid && out_ready);
      if (outst > max_outst) max_outst = outst;
      if (stall_prev && out_valid && ({out_data, out_sop, out_eop} !== held)) stab_err++;
      stall_prev = out_valid && !out_ready;
      held       = {out_data, out_sop, out_eop};
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic load(input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      mem[(wr_ptr + i) % 64] = v;
      v = v + step;
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic do_reset();
    tick();
    reset  = 1'b1;
    wr_ptr = 0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int base, input int n);
    for (int i = 0; i < 200 && rx_dat.size() < base + n; i++) tick();
    chk(tag, rx_dat.size() - base, n);
  endtask

  int b;
  int r0;
  int g0;

  initial begin
    #1 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_rden", fifo_rden, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop_eop", {out_sop, out_eop}, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_word_cnt", word_cnt, 0);

    // Single burst, free-flowing output
    b = rx_dat.size(); r0 = rd_cnt;
    load(4, 8'h11, 8'h11);
    out_ready = 1'b1;
    wait_words("t1_count", b, 4);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("t1_data%0d", i), rx_dat[b + i], 32'(8'h11 * (i + 1)));
    chk("t1_sop", {rx_sop[b], rx_sop[b + 1], rx_sop[b + 2], rx_sop[b + 3]}, 4'b1000);
    chk("t1_eop", {rx_eop[b], rx_eop[b + 1], rx_eop[b + 2], rx_eop[b + 3]}, 4'b0001);
    chk("t1_back_to_back", rx_cyc[b + 3] - rx_cyc[b], 3);
    chk("t1_reads", rd_cnt - r0, 4);
    chk("t1_word_cnt", word_cnt, 4);

    // Fewer than BURST_LEN words never starts a burst
    r0 = rd_cnt;
    load(3, 8'h61, 8'h01);
    repeat (20) tick();
    chk("t2_reads", rd_cnt - r0, 0);
    chk("t2_valid", out_valid, 0);
    chk("t2_word_cnt", word_cnt, 4);

    // Two bursts with toggling backpressure
    do_reset();
    b = rx_dat.size(); r0 = rd_cnt; g0 = rd_gap.size();
    load(8, 8'h31, 8'h01);
    for (int i = 0; i < 100 && rx_dat.size() < b + 8; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    chk("t3_count", rx_dat.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_data%0d", i), rx_dat[b + i], 32'(8'h31 + i));
      chk($sformatf("t3_sop%0d", i), rx_sop[b + i], (i % 4 == 0));
      chk($sformatf("t3_eop%0d", i), rx_eop[b + i], (i % 4 == 3));
    end
    chk("t3_reads", rd_cnt - r0, 8);
    chk("t3_stable", stab_err, 0);
    chk("t3_max_outstanding", (max_outst <= 2), 1);
    chk("t3_burst_gap", (rd_gap[g0 + 4] >= 2), 1);

    // Full backpressure: only two reads fit
    do_reset();
    out_ready = 1'b0;
    b = rx_dat.size(); r0 = rd_cnt;
    load(4, 8'h41, 8'h01);
    repeat (15) tick();
    chk("t4_reads_stalled", rd_cnt - r0, 2);
    chk("t4_rden_low", fifo_rden, 0);
    chk("t4_head", {out_valid, out_sop, out_data}, {2'b11, 8'h41});
    out_ready = 1'b1;
    wait_words("t4_count", b, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_data%0d", i), rx_dat[b + i], 32'(8'h41 + i));
    chk("t4_eop", rx_eop[b + 3], 1);
    chk("t4_reads", rd_cnt - r0, 4);

    // Empty FIFO mid-burst
    chk("t5_underrun_pre", underrun, 0);
    b = rx_dat.size(); r0 = rd_cnt;
    load(4, 8'h51, 8'h01);
    for (int i = 0; i < 50 && !fifo_rden; i++) @(negedge rdclk);
    chk("t5_start", fifo_rden, 1);
    @(posedge rdclk);
    @(posedge rdclk);
    #1 force_empty = 1'b1;
    repeat (4) tick();
    chk("t5_reads_blocked", rd_cnt - r0, 2);
    chk("t5_rden_low", fifo_rden, 0);
    chk("t5_underrun", underrun, 1);
    force_empty = 1'b0;
    wait_words("t5_count", b, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_data%0d", i), rx_dat[b + i], 32'(8'h51 + i));
    chk("t5_sop_eop", {rx_sop[b], rx_eop[b + 3]}, 2'b11);
    repeat (4) tick();
    chk("t5_underrun_sticky", underrun, 1);

    // Asynchronous reset with words buffered
    out_ready = 1'b0;
    load(4, 8'hA1, 8'h01);
    repeat (10) tick();
    chk("t6_buffered", out_valid, 1);
    @(posedge rdclk);
    #2 reset = 1'b1;
    wr_ptr = 0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_rden", fifo_rden, 0);
    chk("t6_async_word_cnt", word_cnt, 0);
    chk("t6_async_underrun", underrun, 0);
    chk("t6_async_data", out_data, 0);
    repeat (2) tick();
    reset = 1'b0;
    b = rx_dat.size();
    load(4, 8'hB1, 8'h01);
    out_ready = 1'b1;
    wait_words("t6_count", b, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_data%0d", i), rx_dat[b + i], 32'(8'hB1 + i));
    chk("t6_sop", {rx_sop[b], rx_sop[b + 1]}, 2'b10);
    chk("t6_eop", rx_eop[b + 3], 1);
    repeat (2) tick();
    chk("t6_word_cnt", word_cnt, 4);

    chk("rden_while_empty", empty_rd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
